// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV32I pipeline: turns ALU address + rs2 into req/gnt + rvalid bus accesses.
// Latency: load = accept, >=1 REQ, >=1 WAIT, wb_valid on the following edge; store completes in the gnt cycle.
// Backpressure: busy (combinational) stalls the pipeline until gnt (store) or rvalid/timeout (load).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ex_valid/load/store/funct3     decoded memory op from execute
//   ex_addr, ex_wdata, ex_rd       effective address, store data, load destination
//   busy                           pipeline stall request
//   mem_req/we/addr/wdata/be       data-memory request (held stable until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata data-memory response
//   wb_valid/wb_rd/wb_data         one-cycle load writeback
//   misalign, bus_err              one-cycle event pulses
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        wb_valid_q, misalign_q, bus_err_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    // Decode: load wins when both load and store are flagged.
    logic is_load, is_store, ld_legal, st_legal, op_legal, mis, accept, drop;
    assign is_load  = ex_load;
    assign is_store = ex_store & ~ex_load;
    assign ld_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                      (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    assign st_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    assign op_legal = ex_valid & ((is_load & ld_legal) | (is_store & st_legal));
    // funct3[1:0] encodes size for every legal code: 00 byte, 01 half, 10 word.
    assign mis      = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (|ex_addr[1:0]));
    assign accept   = op_legal & ~mis;
    assign drop     = op_legal & mis;

    // Store lane placement; loads always request the whole word.
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata;
        if (is_store) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << ex_addr[1:0];
                    wdata_d = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{ex_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load extraction from the lane selected by the captured address offset.
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data_d;
    assign shifted = mem_rdata >> {off_q, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    always_comb begin
        case (f3_q)
            3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data_d = {24'd0, ld_byte};
            3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data_d = {16'd0, ld_half};
            default: ld_data_d = mem_rdata;
        endcase
    end

    // Last WAIT cycle: counter already at TIMEOUT-1 and still no data.
    logic timeout_hit;
    assign timeout_hit = (cnt_q == TO_LAST) & ~mem_rvalid;

    always_comb begin
        case (state_q)
            IDLE:    busy = accept;
            REQ:     busy = ~(mem_gnt & mem_we_q);
            WAIT:    busy = ~(mem_rvalid | timeout_hit);
            default: busy = 1'b0;
        endcase
        if (rst) busy = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            rd_q        <= 5'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    misalign_q <= drop;
                    if (accept) begin
                        state_q     <= REQ;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= {ex_addr[31:2], 2'b00};
                        mem_wdata_q <= wdata_d;
                        mem_be_q    <= be_d;
                        rd_q        <= ex_rd;
                        f3_q        <= ex_funct3;
                        off_q       <= ex_addr[1:0];
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= 8'd0;
                        state_q   <= mem_we_q ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= ld_data_d;
                        state_q    <= IDLE;
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] sb_q[$];   // {rd, data} expected writebacks

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample #1 after the edge; any wb_valid is scoreboarded.
    task automatic tick();
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
                chk("wb_data", wb_data, e[31:0]);
            end
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = d; ex_rd = rd;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic [31:0] expd,
                            input int gdly, input int rdly);
        drive(1'b1, 1'b0, f3, a, 32'h0, rd);
        sb_q.push_back({rd, expd});
        #1 chk("ld_accept_busy", {31'd0, busy}, 32'd1);
        tick();
        clear_ex();
        chk("ld_req", {31'd0, mem_req}, 32'd1);
        chk("ld_addr", mem_addr, {a[31:2], 2'b00});
        chk("ld_be", {28'd0, mem_be}, 32'hF);
        chk("ld_we", {31'd0, mem_we}, 32'd0);
        repeat (gdly) tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("ld_wait_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < rdly; i++) begin
            #1 chk("ld_wait_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        #1 chk("ld_rvalid_busy", {31'd0, busy}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_pulses", {30'd0, misalign, bus_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: LW, gnt first REQ cycle, rvalid two cycles after gnt
        run_load(3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        // 2: extraction; each starts in the wb_valid cycle of the previous one
        run_load(3'b000, 32'h103, 5'd6, 32'h80112233, 32'hFFFFFF80, 0, 0);
        run_load(3'b100, 32'h103, 5'd7, 32'h80112233, 32'h00000080, 1, 0);
        run_load(3'b001, 32'h102, 5'd8, 32'h80015566, 32'hFFFF8001, 0, 2);
        run_load(3'b101, 32'h102, 5'd9, 32'h80015566, 32'h00008001, 0, 0);
        run_load(3'b000, 32'h100, 5'd10, 32'h80112233, 32'h00000033, 0, 0);
        run_load(3'b001, 32'h100, 5'd11, 32'h0000F00D, 32'hFFFFF00D, 0, 0);
        tick();
        chk("wb_pulse_end", {31'd0, wb_valid}, 32'd0);

        // 3: SH 0x202 with gnt held off 3 cycles
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
        #1 chk("sh_accept_busy", {31'd0, busy}, 32'd1);
        tick();
        clear_ex();
        for (int i = 0; i < 4; i++) begin
            chk("sh_req", {31'd0, mem_req}, 32'd1);
            chk("sh_addr", mem_addr, 32'h200);
            chk("sh_be", {28'd0, mem_be}, 32'hC);
            chk("sh_wdata", mem_wdata, 32'hABCDABCD);
            chk("sh_we", {31'd0, mem_we}, 32'd1);
            if (i < 3) begin
                #1 chk("sh_req_busy", {31'd0, busy}, 32'd1);
                tick();
            end
        end
        mem_gnt = 1'b1;
        #1 chk("sh_gnt_busy", {31'd0, busy}, 32'd0);
        tick();
        mem_gnt = 1'b0;
        chk("sh_done_req", {31'd0, mem_req}, 32'd0);
        chk("sh_no_wb", {31'd0, wb_valid}, 32'd0);

        // SB lane 1 and load-wins-over-store
        drive(1'b0, 1'b1, 3'b000, 32'h001, 32'hAABBCC77, 5'd0);
        tick();
        clear_ex();
        chk("sb_be", {28'd0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'h77777777);
        chk("sb_addr", mem_addr, 32'h0);
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        drive(1'b1, 1'b1, 3'b010, 32'h500, 32'h0, 5'd3);
        tick();
        clear_ex();
        chk("both_we", {31'd0, mem_we}, 32'd0);
        chk("both_be", {28'd0, mem_be}, 32'hF);
        sb_q.push_back({5'd3, 32'h01020304});
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h01020304; tick(); mem_rvalid = 1'b0;
        tick();

        // 4: misaligned LW and SH, illegal funct3
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd1);
        #1 chk("mis_lw_busy", {31'd0, busy}, 32'd0);
        tick();
        clear_ex();
        chk("mis_lw_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_lw_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("mis_lw_pulse_end", {31'd0, misalign}, 32'd0);
        drive(1'b0, 1'b1, 3'b001, 32'h301, 32'h0, 5'd0);
        #1 chk("mis_sh_busy", {31'd0, busy}, 32'd0);
        tick();
        clear_ex();
        chk("mis_sh_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_sh_req", {31'd0, mem_req}, 32'd0);
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd1);
        #1 chk("ill_busy", {31'd0, busy}, 32'd0);
        tick();
        clear_ex();
        chk("ill_none", {29'd0, mem_req, misalign, bus_err}, 32'd0);

        // 5: timeout (TIMEOUT=4); rvalid in the gnt cycle must be ignored
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd12);
        tick();
        clear_ex();
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("to_wait_busy", {31'd0, busy}, (i < 4) ? 32'd1 : 32'd0);
            chk("to_no_err", {31'd0, bus_err}, 32'd0);
            tick();
        end
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("to_err_end", {31'd0, bus_err}, 32'd0);
        chk("to_idle_req", {31'd0, mem_req}, 32'd0);

        // 6: asynchronous reset during REQ, then during WAIT
        drive(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd13);
        tick();
        clear_ex();
        chk("r6_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("r6_req_drop", {31'd0, mem_req}, 32'd0);
        chk("r6_busy_drop", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        tick(); tick();
        mem_rvalid = 1'b0;
        chk("r6_late_rv", {31'd0, wb_valid}, 32'd0);

        drive(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 5'd14);
        tick();
        clear_ex();
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        #1 chk("r7_wait_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("r7_busy_drop", {31'd0, busy}, 32'd0);
        chk("r7_req", {31'd0, mem_req}, 32'd0);
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h66666666;
        tick(); tick();
        mem_rvalid = 1'b0;
        chk("r7_late_rv", {31'd0, wb_valid}, 32'd0);
        tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
